// File: rtl/game_sequencer.sv
// Control FSM sequencing spawn/move/drop/lock+clear over a req/ack handshake to the Tetris datapath.
// Optional pause support is compiled in when the PAUSE_EN macro is defined.
module game_sequencer #(
    parameter int GRAVITY_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] key_pulse,
    output logic       op_req,
    output logic [2:0] op_code,
    input  logic       op_ack,
    input  logic       op_ok,
    input  logic [2:0] rows_cleared,
    output logic       board_clr,
    output logic       score_rst,
    output logic       score_hit,
    output logic [1:0] line_cnt,
    output logic       game_over,
    output logic       paused
);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SPAWN_REQ, S_PLAY, S_MOVE_REQ, S_LOCK_REQ, S_OVER
    } state_t;

    localparam logic [2:0] OP_SPAWN = 3'd0, OP_CW = 3'd1, OP_CCW = 3'd2, OP_LEFT = 3'd3,
                           OP_RIGHT = 3'd4, OP_DOWN = 3'd5, OP_DROP = 3'd6, OP_LOCK = 3'd7;

    // Pending bit positions: gravity at 0, key strobes at their key index.
    localparam int K_GRAV = 0, K_RESTART = 1, K_DROP = 2, K_CW = 3,
                   K_CCW = 4, K_LEFT = 5, K_RIGHT = 6;

    localparam int CNT_W = 26;
    localparam logic [CNT_W-1:0] GRAV_LAST = CNT_W'(GRAVITY_CYCLES - 1);

    state_t             state_q, state_d;
    logic [6:0]         pend_q, pend_d;
    logic [CNT_W-1:0]   grav_cnt_q, grav_cnt_d;
    logic               gap_q, gap_d;
    logic [2:0]         op_q, op_d;
    logic               score_hit_q, score_hit_d;
    logic [1:0]         line_cnt_q, line_cnt_d;
    logic               paused_act;
    logic               unused_keys;

    logic               req_state, ack_taken, counting, grav_wrap;
    logic [6:0]         key_set;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        grav_cnt_d  = grav_cnt_q;
        op_d        = op_q;
        score_hit_d = 1'b0;
        line_cnt_d  = line_cnt_q;

        // gap_q forces op_req low for one cycle after every accepted ack.
        req_state = (state_q == S_SPAWN_REQ) || (state_q == S_MOVE_REQ) ||
                    (state_q == S_LOCK_REQ);
        ack_taken = req_state && !gap_q && op_ack;
        gap_d     = ack_taken;

        counting  = ((state_q == S_PLAY) || (state_q == S_MOVE_REQ)) && !paused_act;
        grav_wrap = counting && (grav_cnt_q == GRAV_LAST);
        if (counting) begin
            grav_cnt_d = grav_wrap ? '0 : grav_cnt_q + CNT_W'(1);
        end

        key_set = {key_pulse[6:2] & {5{~paused_act}}, key_pulse[1], 1'b0};
        pend_d  = pend_q | key_set | {6'b0, grav_wrap};

        unique case (state_q)
            S_IDLE: begin
                if (pend_d[K_RESTART]) state_d = S_START;
            end
            S_START: begin
                pend_d     = '0;
                grav_cnt_d = '0;
                state_d    = S_SPAWN_REQ;
            end
            S_SPAWN_REQ: begin
                if (ack_taken) begin
                    grav_cnt_d = '0;
                    if (pend_d[K_RESTART]) state_d = S_START;
                    else if (op_ok)        state_d = S_PLAY;
                    else                   state_d = S_OVER;
                end
            end
            S_PLAY: begin
                // Fixed priority; only one dispatch per visit to PLAY.
                if (pend_q[K_RESTART]) begin
                    pend_d[K_RESTART] = 1'b0;
                    state_d = S_START;
                end else if (!paused_act) begin
                    if (pend_q[K_CW]) begin
                        pend_d[K_CW] = 1'b0;    op_d = OP_CW;    state_d = S_MOVE_REQ;
                    end else if (pend_q[K_CCW]) begin
                        pend_d[K_CCW] = 1'b0;   op_d = OP_CCW;   state_d = S_MOVE_REQ;
                    end else if (pend_q[K_LEFT]) begin
                        pend_d[K_LEFT] = 1'b0;  op_d = OP_LEFT;  state_d = S_MOVE_REQ;
                    end else if (pend_q[K_RIGHT]) begin
                        pend_d[K_RIGHT] = 1'b0; op_d = OP_RIGHT; state_d = S_MOVE_REQ;
                    end else if (pend_q[K_DROP]) begin
                        pend_d[K_DROP] = 1'b0;  op_d = OP_DROP;  state_d = S_MOVE_REQ;
                    end else if (pend_q[K_GRAV]) begin
                        pend_d[K_GRAV] = 1'b0;  op_d = OP_DOWN;  state_d = S_MOVE_REQ;
                    end
                end
            end
            S_MOVE_REQ: begin
                if (ack_taken) begin
                    if (pend_d[K_RESTART])                             state_d = S_START;
                    else if (op_q == OP_DROP || (op_q == OP_DOWN && !op_ok)) state_d = S_LOCK_REQ;
                    else                                               state_d = S_PLAY;
                end
            end
            S_LOCK_REQ: begin
                if (ack_taken) begin
                    if (rows_cleared != 3'd0) begin
                        score_hit_d = 1'b1;
                        line_cnt_d  = rows_cleared[2] ? 2'd3 : rows_cleared[1:0] - 2'd1;
                    end
                    pend_d[6:2]    = '0;
                    pend_d[K_GRAV] = 1'b0;
                    state_d = pend_d[K_RESTART] ? S_START : S_SPAWN_REQ;
                end
            end
            S_OVER: begin
                pend_d = {5'b0, pend_d[K_RESTART], 1'b0};
                if (pend_d[K_RESTART]) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pend_q      <= '0;
            grav_cnt_q  <= '0;
            gap_q       <= 1'b0;
            op_q        <= OP_SPAWN;
            score_hit_q <= 1'b0;
            line_cnt_q  <= 2'd0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            grav_cnt_q  <= grav_cnt_d;
            gap_q       <= gap_d;
            op_q        <= op_d;
            score_hit_q <= score_hit_d;
            line_cnt_q  <= line_cnt_d;
        end
    end

`ifdef PAUSE_EN
    logic paused_q, paused_d;

    always_comb begin
        paused_d = paused_q;
        if (key_pulse[0] && ((state_q == S_PLAY) || (state_q == S_MOVE_REQ) ||
                             (state_q == S_LOCK_REQ) || (state_q == S_SPAWN_REQ))) begin
            paused_d = ~paused_q;
        end
        if (state_d == S_START) paused_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) paused_q <= 1'b0;
        else        paused_q <= paused_d;
    end

    assign paused_act  = paused_q;
    assign unused_keys = key_pulse[7];
`else
    assign paused_act  = 1'b0;
    assign unused_keys = ^{key_pulse[7], key_pulse[0]};
`endif

    always_comb begin
        op_code = OP_SPAWN;
        unique case (state_q)
            S_LOCK_REQ: op_code = OP_LOCK;
            S_MOVE_REQ: op_code = op_q;
            default:    op_code = OP_SPAWN;
        endcase
    end

    assign op_req    = req_state && !gap_q;
    assign board_clr = (state_q == S_START);
    assign score_rst = (state_q == S_START);
    assign score_hit = score_hit_q;
    assign line_cnt  = line_cnt_q;
    assign game_over = (state_q == S_OVER);
    assign paused    = paused_act;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: handshake ordering, gravity period, lock/score, game over, restart.
module tb_game_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] key_pulse;
    logic       op_req;
    logic [2:0] op_code;
    logic       op_ack;
    logic       op_ok;
    logic [2:0] rows_cleared;
    logic       board_clr, score_rst, score_hit, game_over, paused;
    logic [1:0] line_cnt;
    logic [10:0] outs;

    int n_checks = 0;
    int n_fail   = 0;

    game_sequencer #(.GRAVITY_CYCLES(1000)) dut (
        .clk(clk), .rst_n(rst_n), .key_pulse(key_pulse),
        .op_req(op_req), .op_code(op_code), .op_ack(op_ack), .op_ok(op_ok),
        .rows_cleared(rows_cleared), .board_clr(board_clr), .score_rst(score_rst),
        .score_hit(score_hit), .line_cnt(line_cnt), .game_over(game_over), .paused(paused)
    );

    always #5 clk = ~clk;

    assign outs = {op_req, op_code, board_clr, score_rst, score_hit, line_cnt, game_over, paused};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_keys(input logic [7:0] k);
        key_pulse = k;
        tick(1);
        key_pulse = 8'h00;
    endtask

    task automatic wait_req(input string tag, input logic [2:0] code, input int budget,
                            output int cycles);
        cycles = 0;
        while (!op_req && cycles < budget) begin
            tick(1);
            cycles++;
        end
        check_eq({tag, "_req"}, 32'(op_req), 32'd1);
        check_eq({tag, "_code"}, 32'(op_code), 32'(code));
    endtask

    task automatic do_ack(input string tag, input logic ok, input logic [2:0] rows,
                          input int delay);
        logic [2:0] code0;
        code0 = op_code;
        for (int i = 0; i < delay; i++) begin
            tick(1);
            check_eq({tag, "_hold"}, 32'({op_req, op_code}), 32'({1'b1, code0}));
        end
        op_ack = 1'b1;
        op_ok = ok;
        rows_cleared = rows;
        tick(1);
        op_ack = 1'b0;
        op_ok = 1'b0;
        rows_cleared = 3'd0;
        check_eq({tag, "_drop"}, 32'(op_req), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        key_pulse = 8'h00;
        op_ack = 1'b0;
        op_ok = 1'b0;
        rows_cleared = 3'd0;
        tick(2);
        check_eq("reset_outs", 32'(outs), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // A move key in IDLE must not start anything.
        pulse_keys(8'b0000_1000);
        tick(4);
        check_eq("idle_ignore", 32'({op_req, board_clr}), 32'd0);

        pulse_keys(8'b0000_0010);
        check_eq("start_pulse", 32'({board_clr, score_rst}), 32'b11);
        tick(1);
        check_eq("start_once", 32'({board_clr, score_rst}), 32'b00);
        wait_req("spawn1", 3'd0, 5, n);
        do_ack("spawn1", 1'b1, 3'd0, 0);

        wait_req("grav", 3'd5, 1100, n);
        check_eq("grav_period", 32'(n >= 998 && n <= 1002), 32'd1);
        do_ack("grav", 1'b1, 3'd0, 0);

        // cw + left + right together dispatch in priority order with slow acks.
        pulse_keys(8'b0110_1000);
        wait_req("multi_cw", 3'd1, 10, n);
        do_ack("multi_cw", 1'b0, 3'd0, 5);
        wait_req("multi_left", 3'd3, 10, n);
        do_ack("multi_left", 1'b1, 3'd0, 5);
        wait_req("multi_right", 3'd4, 10, n);
        do_ack("multi_right", 1'b1, 3'd0, 5);

        wait_req("down", 3'd5, 1100, n);
        do_ack("down", 1'b0, 3'd0, 0);
        wait_req("lock3", 3'd7, 5, n);
        do_ack("lock3", 1'b1, 3'd3, 0);
        check_eq("hit3", 32'(score_hit), 32'd1);
        check_eq("line3", 32'(line_cnt), 32'd2);
        tick(1);
        check_eq("hit3_once", 32'(score_hit), 32'd0);
        wait_req("spawn2", 3'd0, 5, n);
        do_ack("spawn2", 1'b0, 3'd0, 0);
        check_eq("over", 32'(game_over), 32'd1);
        pulse_keys(8'b0111_1100);
        tick(5);
        check_eq("over_ignore", 32'({op_req, game_over}), 32'b01);

        pulse_keys(8'b0000_0010);
        check_eq("restart_over", 32'({board_clr, game_over}), 32'b10);
        wait_req("spawn3", 3'd0, 5, n);
        do_ack("spawn3", 1'b1, 3'd0, 0);

        pulse_keys(8'b0000_0100);
        wait_req("drop", 3'd6, 10, n);
        do_ack("drop", 1'b0, 3'd0, 0);
        wait_req("lock0", 3'd7, 5, n);
        pulse_keys(8'b0000_0010);
        check_eq("lock0_held", 32'(op_req), 32'd1);
        do_ack("lock0", 1'b1, 3'd0, 0);
        check_eq("lock0_nohit", 32'(score_hit), 32'd0);
        check_eq("lock0_line", 32'(line_cnt), 32'd2);
        check_eq("lock0_restart", 32'(score_rst), 32'd1);
        wait_req("spawn4", 3'd0, 5, n);
        do_ack("spawn4", 1'b1, 3'd0, 0);

        // rows_cleared above 4 saturates line_cnt at 3.
        pulse_keys(8'b0000_0100);
        wait_req("drop2", 3'd6, 10, n);
        do_ack("drop2", 1'b1, 3'd0, 2);
        wait_req("lock7", 3'd7, 5, n);
        do_ack("lock7", 1'b1, 3'd7, 0);
        check_eq("hit7", 32'({score_hit, line_cnt}), 32'b111);
        wait_req("spawn5", 3'd0, 5, n);
        do_ack("spawn5", 1'b1, 3'd0, 0);

`ifdef PAUSE_EN
        pulse_keys(8'b0000_0001);
        check_eq("pause_on", 32'(paused), 32'd1);
        pulse_keys(8'b0010_0000);
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            tick(1);
            if (op_req) n++;
        end
        check_eq("pause_quiet", 32'(n), 32'd0);
        pulse_keys(8'b0000_0001);
        check_eq("pause_off", 32'(paused), 32'd0);
        wait_req("pause_grav", 3'd5, 1100, n);
        do_ack("pause_grav", 1'b1, 3'd0, 0);
`else
        pulse_keys(8'b0000_0001);
        tick(2);
        check_eq("pause_absent", 32'({paused, op_req}), 32'd0);
`endif

        // Asynchronous reset while a move is in flight.
        pulse_keys(8'b0010_0000);
        wait_req("left_rst", 3'd3, 10, n);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst", 32'(outs), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulse_keys(8'b0000_1000);
        tick(5);
        check_eq("post_rst_idle", 32'({op_req, board_clr, game_over}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Control FSM for the Tetris move/collide/lock/eliminate datapath.
- Replaces the single-cycle cascade of chained collision checkers with one serialized operation at a time, carried over a req/ack handshake.
- Latches keyboard strobes, generates the gravity tick, and orders the operations spawn, rotate, shift, down, drop and lock+clear.
- Drives the score-counter and game-over status.

Parameters:
- GRAVITY_CYCLES, default 1000: clk cycles between gravity steps while playing; top overrides it with 50_000_000. Legal range 2..2^26-1.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- key_pulse  in  8  one-cycle strobes from key decoder, codebase key indices: [0] pause, [1] restart, [2] drop, [3] cw, [4] ccw, [5] left, [6] right, [7] unused
- op_req  out  1  operation request to datapath
- op_code  out  3  0 SPAWN, 1 CW, 2 CCW, 3 LEFT, 4 RIGHT, 5 DOWN, 6 DROP, 7 LOCK_CLEAR
- op_ack  in  1  one-cycle completion from datapath
- op_ok  in  1  sampled with op_ack: 1 = move applied / spawn fits
- rows_cleared  in  3  sampled with op_ack of LOCK_CLEAR, 0..4
- board_clr  out  1  one-cycle pulse: datapath clears static board
- score_rst  out  1  one-cycle pulse to scoreCount reset
- score_hit  out  1  one-cycle pulse: rows eliminated
- line_cnt  out  2  rows_cleared-1, valid with score_hit, held until next hit
- game_over  out  1  level: game ended
- paused  out  1  level: pause active (0 without PAUSE_EN)

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, op_code 0.
  - Pending bits and gravity counter cleared.
- States:
  - IDLE: waits for restart.
  - START: board_clr and score_rst asserted for one cycle; pending and counter cleared; then SPAWN_REQ.
  - SPAWN_REQ: op_req with op_code 0; waits for ack.
  - PLAY: dispatch state.
  - MOVE_REQ: op_req with latched op; waits for ack.
  - LOCK_REQ: op_req with op_code 7.
  - OVER: game_over=1.
- Handshake:
  - op_req rises with op_code valid and stays high, op_code stable, until the cycle op_ack=1.
  - op_req drops the cycle after ack.
  - Next op_req no earlier than 1 cycle after the drop.
  - op_ack while op_req=0 is ignored.
  - The datapath may ack in the same cycle op_req rises.
- Pending latches:
  - One bit per key [1..6] plus gravity.
  - Set on strobe in any state; a repeat strobe while set is absorbed.
  - Cleared when dispatched.
- PLAY dispatch, one per visit, fixed priority: restart > cw > ccw > left > right > drop > gravity.
  - Restart goes to START.
  - Nothing pending: stay in PLAY.
- Gravity counter:
  - Counts clk only in PLAY/MOVE_REQ.
  - At GRAVITY_CYCLES-1, sets gravity pending and wraps to 0.
  - Reset to 0 on each SPAWN ack.
- Ack outcomes:
  - CW/CCW/LEFT/RIGHT, either op_ok: back to PLAY.
  - DOWN: op_ok=1 goes to PLAY; op_ok=0 goes to LOCK_REQ.
  - DROP: goes to LOCK_REQ regardless of op_ok.
  - LOCK_CLEAR: if rows_cleared≠0, score_hit=1 for one cycle and line_cnt=rows_cleared-1. Then SPAWN_REQ, with key pending bits [2..6] and gravity cleared.
  - SPAWN: op_ok=1 goes to PLAY; op_ok=0 goes to OVER.
- Restart:
  - In IDLE/OVER: taken the cycle after the strobe; clears game_over.
  - In a *_REQ state: restart stays pending and the in-flight op completes first.
  - Outcome handling after that ack: a LOCK_CLEAR ack still reports score; then START, overriding SPAWN_REQ/LOCK_REQ.
- OVER: all strobes except restart (and pause) discarded, pending cleared.
- Simultaneous events:
  - Strobe in the same cycle as its dispatch: the new strobe is absorbed.
  - Gravity wrap in a LOCK ack cycle: discarded.
- rows_cleared>4 is treated as 4 (line_cnt=3).

Optional Feature:
- Macro PAUSE_EN.
- Enabled:
  - key_pulse[0] toggles paused, but only in PLAY/MOVE_REQ/LOCK_REQ/SPAWN_REQ.
  - While paused: gravity counter frozen; strobes [2..6] discarded; PLAY dispatches only restart.
  - Any in-flight op completes normally.
  - Restart and reset clear paused.
- Disabled: key_pulse[0] ignored; paused tied 0; no pause logic synthesized.

Test Plan:
- Reset mid-MOVE_REQ (op_req=1), rst_n low 1 cycle: all outputs 0 asynchronously, state IDLE; key_pulse[3] alone then does nothing.
- key_pulse[1] in IDLE: board_clr=score_rst=1 for exactly 1 cycle, then op_req with op_code=0. Ack op_ok=1, then with GRAVITY_CYCLES=1000, op_req op_code=5 appears 1000 cycles after the ack (±2).
- key_pulse[3,5,6] in the same cycle in PLAY: ops issued in order 1, 3, 4, each with req held until an ack delayed by 5 cycles; op_code stable throughout.
- DOWN acked op_ok=0: next op_code=7. Ack with rows_cleared=3: score_hit 1 cycle, line_cnt=2, then op_code=0. Ack SPAWN op_ok=0: game_over=1, move strobes ignored.
- DROP ack, then LOCK_CLEAR with rows_cleared=0: no score_hit, line_cnt unchanged. key_pulse[1] during LOCK_REQ: START follows the LOCK ack, score_rst pulses.
- PAUSE_EN: key_pulse[0] in PLAY sets paused=1; 3000 cycles pass with no op_req and left strobes discarded. Second key_pulse[0] resumes; gravity fires after the remaining count.
